// File: rtl/uart_points_tx_sched.sv
// Round-robin arbiter sharing one UART TX between two 24-bit points sources; frames go out LSB byte first.
// Optional `UART_POINTS_HDR_EN prepends a per-source header byte (A1/A2) to each frame.
module uart_points_tx_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 24'd2_000_000,
  parameter int unsigned TO_W           = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1,
  input  logic [23:0] points1,
  input  logic        req2,
  input  logic [23:0] points2,
  input  logic        tx_done_tick,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        ack1,
  output logic        ack2,
  output logic        busy,
  output logic        tx_err
);

  // state | meaning: IDLE arbitrate | LOAD present byte | WAIT_DONE await tick | FINISH ack owner
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, FINISH} state_t;

`ifdef UART_POINTS_HDR_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [23:0]     frame, frame_n;
  logic            owner, owner_n;         // 0 = source 1, 1 = source 2
  logic            last_grant, last_grant_n;
  logic [1:0]      byte_cnt, byte_cnt_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            tx_start_n;
  logic [7:0]      tx_data_n;
  logic            ack1_n, ack2_n, busy_n, tx_err_n;
  logic [7:0]      cur_byte;

  always_comb begin
    cur_byte = frame[7:0];
`ifdef UART_POINTS_HDR_EN
    case (byte_cnt)
      2'd0:    cur_byte = owner ? 8'hA2 : 8'hA1;
      2'd1:    cur_byte = frame[7:0];
      2'd2:    cur_byte = frame[15:8];
      default: cur_byte = frame[23:16];
    endcase
`else
    case (byte_cnt)
      2'd0:    cur_byte = frame[7:0];
      2'd1:    cur_byte = frame[15:8];
      default: cur_byte = frame[23:16];
    endcase
`endif
  end

  always_comb begin
    state_n      = state;
    frame_n      = frame;
    owner_n      = owner;
    last_grant_n = last_grant;
    byte_cnt_n   = byte_cnt;
    to_cnt_n     = to_cnt;
    tx_start_n   = 1'b0;
    tx_data_n    = tx_data;
    ack1_n       = 1'b0;
    ack2_n       = 1'b0;
    tx_err_n     = tx_err;
    case (state)
      IDLE: begin
        if (req1 && (!req2 || last_grant)) begin
          frame_n      = points1;
          owner_n      = 1'b0;
          last_grant_n = 1'b0;
          byte_cnt_n   = 2'd0;
          state_n      = LOAD;
        end else if (req2) begin
          frame_n      = points2;
          owner_n      = 1'b1;
          last_grant_n = 1'b1;
          byte_cnt_n   = 2'd0;
          state_n      = LOAD;
        end
      end
      LOAD: begin
        tx_data_n  = cur_byte;
        tx_start_n = 1'b1;
        to_cnt_n   = '0;
        state_n    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A tick in the same cycle as our own start pulse cannot belong to this byte.
        if (tx_done_tick && !tx_start) begin
          if (byte_cnt == LAST_IDX) begin
            ack1_n  = ~owner;
            ack2_n  = owner;
            state_n = FINISH;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
            state_n    = LOAD;
          end
        end else if (to_cnt == TO_LAST) begin
          tx_err_n = 1'b1;
          state_n  = IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      byte_cnt   <= 2'd0;
      to_cnt     <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      ack1       <= 1'b0;
      ack2       <= 1'b0;
      busy       <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_n;
      frame      <= frame_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      byte_cnt   <= byte_cnt_n;
      to_cnt     <= to_cnt_n;
      tx_start   <= tx_start_n;
      tx_data    <= tx_data_n;
      ack1       <= ack1_n;
      ack2       <= ack2_n;
      busy       <= busy_n;
      tx_err     <= tx_err_n;
    end
  end

endmodule

// File: tb/tb_uart_points_tx_sched.sv
// Scoreboard bench for uart_points_tx_sched: expected bytes/acks are queued by stimulus, popped by a monitor.
module tb_uart_points_tx_sched;

  logic        clk, rst_n;
  logic        req1, req2;
  logic [23:0] points1, points2;
  logic        tick_resp, tick_spur;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        ack1, ack2, busy, tx_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int         ack_q[$];
  bit         resp_en;

  assign tx_done_tick = tick_resp | tick_spur;

  uart_points_tx_sched #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req1), .points1(points1),
    .req2(req2), .points2(points2),
    .tx_done_tick(tx_done_tick),
    .tx_start(tx_start), .tx_data(tx_data),
    .ack1(ack1), .ack2(ack2),
    .busy(busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_frame(input int src, input logic [23:0] pts, input int n);
    logic [7:0] b[$];
`ifdef UART_POINTS_HDR_EN
    b.push_back(src == 1 ? 8'hA1 : 8'hA2);
`endif
    b.push_back(pts[7:0]);
    b.push_back(pts[15:8]);
    b.push_back(pts[23:16]);
    for (int i = 0; i < b.size() && i < n; i++) exp_q.push_back(b[i]);
  endfunction

  // UART model: answers each start with a done tick 10 cycles later.
  initial begin
    tick_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start && resp_en) begin
        repeat (10) @(posedge clk);
        #1 tick_resp = 1'b1;
        @(posedge clk);
        #1 tick_resp = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] e;
    int         a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_data unexpected byte got %0h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              errors++;
              $display("FAIL tx_data got %0h expected %0h", tx_data, e);
            end
          end
        end
        if (ack1 || ack2) begin
          checks++;
          if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack unexpected got ack1=%0b ack2=%0b expected none", ack1, ack2);
          end else begin
            a = ack_q.pop_front();
            if ({ack2, ack1} !== ((a == 1) ? 2'b01 : 2'b10)) begin
              errors++;
              $display("FAIL ack_order got ack1=%0b ack2=%0b expected source %0d", ack1, ack2, a);
            end
          end
        end
      end
    end
  end

  task automatic wait_tx_start(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tx_start_wait got no start expected start within %0d cycles", budget);
    end
  endtask

  task automatic wait_ack(input int src, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((src == 1) ? ack1 : ack2) seen = 1;
    end
    if (src == 1) req1 = 1'b0;
    else          req2 = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_wait got no ack%0d expected ack within %0d cycles", src, budget);
    end else begin
      @(negedge clk);
      chk("idle_after_ack_busy", busy, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clk = 0; rst_n = 0;
    req1 = 0; req2 = 0; points1 = '0; points2 = '0;
    tick_spur = 0; resp_en = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ack", {ack2, ack1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_err", tx_err, 0);
    rst_n = 1;

    // Single frame plus request-to-start latency.
    @(posedge clk);
    #1 points1 = 24'h123456; req1 = 1;
    push_frame(1, 24'h123456, 99); ack_q.push_back(1);
    @(posedge clk);
    @(negedge clk);
    chk("load_no_start", tx_start, 0);
    chk("load_busy", busy, 1);
    @(negedge clk);
    chk("start_latency", tx_start, 1);
    wait_ack(1, 200);

    // Simultaneous requests, twice: source 1 wins each time after source 2 was last.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1 points1 = 24'h0000AA; points2 = 24'h0000BB; req1 = 1; req2 = 1;
      push_frame(1, 24'h0000AA, 99); push_frame(2, 24'h0000BB, 99);
      ack_q.push_back(1); ack_q.push_back(2);
      wait_ack(1, 200);
      @(negedge clk);
      chk("b2b_one_idle_busy", busy, 1);
      wait_ack(2, 200);
    end

    // Captured points and spurious ticks in IDLE, LOAD and the start cycle.
    @(posedge clk);
    #1 tick_spur = 1;
    @(posedge clk);
    #1 tick_spur = 0; points1 = 24'h0A0B0C; req1 = 1;
    push_frame(1, 24'h0A0B0C, 99); ack_q.push_back(1);
    @(posedge clk);
    #1 tick_spur = 1;
    @(posedge clk);
    #1 points1 = 24'hFFFFFF;
    @(posedge clk);
    #1 tick_spur = 0;
    wait_ack(1, 200);

    // Timeout with no tick, then retry from byte 0.
    resp_en = 0;
    @(posedge clk);
    #1 points1 = 24'h112233; req1 = 1;
    push_frame(1, 24'h112233, 1);
    wait_tx_start(50);
    repeat (15) @(negedge clk);
    chk("pre_timeout_err", tx_err, 0);
    chk("pre_timeout_busy", busy, 1);
    @(negedge clk);
    chk("timeout_err", tx_err, 1);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_ack", ack1, 0);
    resp_en = 1;
    push_frame(1, 24'h112233, 99); ack_q.push_back(1);
    wait_ack(1, 200);
    chk("err_sticky", tx_err, 1);

    // Async reset mid-frame, then full frame after release.
    @(posedge clk);
    #1 points1 = 24'hABCDEF; req1 = 1;
    push_frame(1, 24'hABCDEF, 2);
    wait_tx_start(50);
    wait_tx_start(50);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("async_rst_tx_start", tx_start, 0);
    chk("async_rst_tx_data", tx_data, 8'h00);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tx_err", tx_err, 0);
    chk("async_rst_ack", {ack2, ack1}, 0);
    push_frame(1, 24'hABCDEF, 99); ack_q.push_back(1);
    repeat (12) @(posedge clk);
    #1 rst_n = 1;
    wait_ack(1, 200);

    repeat (5) @(negedge clk);
    chk("bytes_drained", exp_q.size(), 0);
    chk("acks_drained", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_points_tx_sched.md
Name: uart_points_tx_sched

Overview:
- Round-robin scheduler sharing one UART transmitter between two 24-bit score/points sources (player 1, player 2).
- On grant, captures the winner's points word and serializes it as 3 bytes, LSB byte first, using the UART tx_start/tx_done_tick handshake.
- Acknowledges the requester when its frame completes.
- Replaces per-UART free-running byte muxing with a single sequenced, race-free transmit path.

Parameters:
- TIMEOUT_CYCLES, 24'd2_000_000: max clk cycles waiting for tx_done_tick per byte before abort.
- TO_W, 24: width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req1  in  1  source 1 frame request, level; held until ack1
- points1  in  24  source 1 points word
- req2  in  1  source 2 frame request, level; held until ack2
- points2  in  24  source 2 points word
- tx_done_tick  in  1  UART TX byte-complete pulse, 1 cycle
- tx_start  out  1  UART TX start pulse, 1 cycle
- tx_data  out  8  byte to transmit; valid with tx_start, held until next tx_start
- ack1  out  1  1-cycle pulse: source 1 frame fully sent
- ack2  out  1  1-cycle pulse: source 2 frame fully sent
- busy  out  1  high in any state except IDLE
- tx_err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (rst_n low, async): state=IDLE; tx_start=0, tx_data=8'h00, ack1=ack2=0, busy=0, tx_err=0, byte_cnt=0, last_grant=2 (so source 1 wins the first tie), timeout counter=0. Reset mid-frame aborts silently; no ack is issued.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT_DONE, FINISH.
- IDLE:
  - Sample req1/req2 each edge.
  - If exactly one request is high, grant it.
  - If both are high, grant the source not equal to last_grant.
  - On grant: capture pointsN into frame[23:0], set owner and last_grant, set byte_cnt=0, go to LOAD.
  - points inputs are not sampled again until the next grant.
- LOAD:
  - tx_data = byte selected by byte_cnt: 0→frame[7:0], 1→frame[15:8], 2→frame[23:16].
  - tx_start=1 for exactly this cycle; clear timeout counter; go to WAIT_DONE.
  - Latency: req sampled high at edge k → tx_start high in the cycle after edge k+1.
- WAIT_DONE:
  - tx_start=0; timeout counter increments each cycle.
  - On tx_done_tick: if byte_cnt==last index, go to FINISH; else byte_cnt+1 and go to LOAD.
  - tx_done_tick in any other state is ignored. This includes a tick coincident with tx_start.
  - If the counter reaches TIMEOUT_CYCLES-1 without a tick: set tx_err=1, go to IDLE without ack. The requester stays pending and is re-served under the normal arbitration rule.
- FINISH:
  - ackN=1 for one cycle for owner; go to IDLE.
  - The requester drops req in the cycle after ack. A req still high 2+ cycles after ack is treated as a new request.
  - A request arriving during FINISH is evaluated in IDLE next cycle. Back-to-back frames therefore have exactly 1 IDLE cycle between them.
- Requests deasserted before grant are simply not served; no state change.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_POINTS_HDR_EN.
- Defined:
  - Each frame is 4 bytes: header first, then the 3 points bytes LSB-first.
  - Header = 8'hA1 for source 1, 8'hA2 for source 2.
  - byte_cnt runs 0..3; last index=3.
  - A timeout on any byte aborts the whole frame.
- Undefined:
  - No header; 3 bytes; last index=2.

Test Plan:
- Reset then req1=1, points1=24'h123456, tx_done_tick returned 10 cycles after each tx_start → tx_data sequence 56,34,12 (with _HDR_EN: A1,56,34,12); one ack1 pulse after the last tick; busy low the cycle after ack1.
- req1 and req2 high in the same cycle, points1=24'h0000AA, points2=24'h0000BB → source 1 frame sent first, then source 2; ack1 precedes ack2; after the next simultaneous request, source 1 is served first again because last_grant=2.
- During the source 1 frame, change points1 to 24'hFFFFFF after grant → transmitted bytes are still the captured value; spurious tx_done_tick in IDLE/LOAD → no byte_cnt advance.
- Never return tx_done_tick, TIMEOUT_CYCLES=16 → tx_err=1 and state IDLE 16 cycles after tx_start; no ack; req1 still high → frame restarts at byte 0.
- Deassert rst_n between byte 1 and byte 2 → all outputs go to reset values immediately (async); no ack; after release with req1 high → full frame from byte 0.
